// File: rtl/timer_ctrl.sv
// timer_ctrl: bus-mapped compare/interrupt stage for the ns hardware timer
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   sel_i, we_i         bus access valid / write (1) or read (0)
//   addr_i, wdata_i     word index and write data
//   rdata_o             registered read data
//   ns_cnt_i            timer ns count
//   overflow_was_i      timer sticky overflow flag
//   to_clear_timer_o    one-cycle synchronous clear request to the timer
//   irq_o               registered level interrupt (PEND & IRQ_EN)
// Registers: 0 CTRL {IRQ_EN,PERIODIC,EN}, 1 CMP, 2 COUNT, 3 STATUS {OVF,PEND}, 4 MCNT
// Optional: define TIMER_CTRL_MATCH_CNT_EN for the saturating match counter at index 4
module timer_ctrl #(
  parameter int NS_CNT_WIDTH = 30,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sel_i,
  input  logic                    we_i,
  input  logic [2:0]              addr_i,
  input  logic [31:0]             wdata_i,
  output logic [31:0]             rdata_o,
  input  logic [NS_CNT_WIDTH-1:0] ns_cnt_i,
  input  logic                    overflow_was_i,
  output logic                    to_clear_timer_o,
  output logic                    irq_o
);
  typedef enum logic [1:0] {IDLE, ARMED, RELOAD, DONE} state_t;
  state_t state, state_n;
  logic en, per, ie, pend, pend_n;
  logic [NS_CNT_WIDTH-1:0] cmp;
  logic wr, rd, wr_ctrl, wr_cmp, wr_cnt, wr_sts, arm, match, hit, unused_ok;
  logic [31:0] mcnt_rd, rd_mux;
  assign wr = sel_i & we_i;
  assign rd = sel_i & ~we_i;
  assign wr_ctrl = wr & (addr_i == 3'd0);
  assign wr_cmp = wr & (addr_i == 3'd1);
  assign wr_cnt = wr & (addr_i == 3'd2);
  assign wr_sts = wr & (addr_i == 3'd3);
  assign arm = wr_ctrl & wdata_i[0];
  assign match = en & (cmp != '0) & (ns_cnt_i >= cmp);
  assign hit = (state == ARMED) & match;
  // Clear is combinational so the timer restarts on the same edge the match
  // is seen; otherwise the count would overshoot CMP by one step in periodic mode.
  // A CTRL write takes priority over the reload, so EN=0 suppresses its clear.
  always_comb begin
    state_n = wr_ctrl ? (wdata_i[0] ? ARMED : IDLE) :
              hit ? (per ? RELOAD : DONE) :
              (state == RELOAD) ? ARMED : state;
    pend_n = hit | (pend & ~(wr_sts & wdata_i[0]));
    to_clear_timer_o = rst_n & (arm | wr_cnt | (hit & per & ~wr_ctrl));
  end
  assign rd_mux = (addr_i == 3'd0) ? {29'b0, ie, per, en} :
                  (addr_i == 3'd1) ? 32'(cmp) :
                  (addr_i == 3'd2) ? 32'(ns_cnt_i) :
                  (addr_i == 3'd3) ? {30'b0, overflow_was_i, pend} :
                  (addr_i == 3'd4) ? mcnt_rd : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {ie, per, en} <= '0;
      cmp <= '0;
      pend <= 1'b0;
      irq_o <= 1'b0;
      rdata_o <= '0;
    end else begin
      pend <= pend_n;
      irq_o <= pend & ie;
      if (wr_ctrl) {ie, per, en} <= wdata_i[2:0];
      if (wr_cmp) cmp <= wdata_i[NS_CNT_WIDTH-1:0];
      if (rd) rdata_o <= rd_mux;
    end
`ifdef TIMER_CTRL_MATCH_CNT_EN
  logic [CNT_W-1:0] mcnt;
  logic wr_mcnt;
  assign wr_mcnt = wr & (addr_i == 3'd4);
  // A clearing write that coincides with a match leaves the counter at 1.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) mcnt <= '0;
    else if (wr_mcnt) mcnt <= CNT_W'(hit);
    else if (hit && !(&mcnt)) mcnt <= mcnt + CNT_W'(1);
  assign mcnt_rd = 32'(mcnt);
  assign unused_ok = ^wdata_i;
`else
  assign mcnt_rd = '0;
  assign unused_ok = ^{wdata_i, 32'(CNT_W)};
`endif
endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl: directed self-checking bench for timer_ctrl with a stepping timer model
module tb_timer_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, sel = 1'b0, we = 1'b0, ovf = 1'b0;
  logic [2:0] addr = '0;
  logic [31:0] wdata = '0, rdata;
  logic [29:0] ns = '0;
  logic clr, irq;
  int step = 0, clr_cnt = 0, checks = 0, failures = 0;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    ns <= clr ? '0 : ns + 30'(step);
    if (clr) clr_cnt <= clr_cnt + 1;
  end
  timer_ctrl dut (
    .clk(clk), .rst_n(rst_n), .sel_i(sel), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .rdata_o(rdata), .ns_cnt_i(ns), .overflow_was_i(ovf), .to_clear_timer_o(clr), .irq_o(irq)
  );
`ifdef TIMER_CTRL_MATCH_CNT_EN
  logic [31:0] rdata2;
  logic clr2, irq2;
  timer_ctrl #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .sel_i(sel), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .rdata_o(rdata2), .ns_cnt_i(ns), .overflow_was_i(ovf), .to_clear_timer_o(clr2), .irq_o(irq2)
  );
`endif
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic exp_clr, input string tag);
    sel = 1'b1; we = 1'b1; addr = a; wdata = d;
    #1 chk(tag, 32'(clr), 32'(exp_clr));
    @(negedge clk);
    sel = 1'b0; we = 1'b0;
  endtask
  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    sel = 1'b1; we = 1'b0; addr = a;
    @(negedge clk);
    sel = 1'b0;
    d = rdata;
  endtask
  task automatic wait_ns(input logic [29:0] v, input string tag);
    int n;
    n = 0;
    while (ns !== v && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(ns), 32'(v));
  endtask
  initial begin
    logic [31:0] d, e;
    logic [29:0] mx;
    int base;
    tick(2);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_clr", 32'(clr), 0);
    chk("rst_rdata", rdata, 0);
    rst_n = 1'b1;
    tick(1);
    for (int i = 0; i < 5; i++) begin
      rd(3'(i), d);
      chk($sformatf("rst_rd%0d", i), d, 0);
    end
    chk("idle_irq", 32'(irq), 0);
    step = 20;
    wr(3'd1, 100, 1'b0, "os_cmp_wr");
    wr(3'd0, 5, 1'b1, "os_arm_clr");
    base = clr_cnt;
    tick(5);
    chk("os_at100_irq", 32'(irq), 0);
    tick(1);
    chk("os_pend_irq_lag", 32'(irq), 0);
    tick(1);
    chk("os_irq", 32'(irq), 1);
    rd(3'd3, d);
    chk("os_status", d, 1);
    tick(3);
    chk("os_no_more_clr", 32'(clr_cnt - base), 0);
    chk("os_irq_hold", 32'(irq), 1);
    wr(3'd0, 0, 1'b0, "os_stop");
    wr(3'd3, 1, 1'b0, "os_w1c");
    wr(3'd1, 60, 1'b0, "per_cmp_wr");
    wr(3'd0, 7, 1'b1, "per_arm_clr");
    base = clr_cnt;
    mx = '0;
    repeat (12) begin
      @(negedge clk);
      if (ns > mx) mx = ns;
    end
    chk("per_clr_count", 32'(clr_cnt - base), 3);
    chk("per_max_count", 32'(mx), 60);
    chk("per_irq", 32'(irq), 1);
    wr(3'd3, 1, 1'b0, "per_w1c");
    chk("per_irq_after_w1c", 32'(irq), 1);
    tick(1);
    chk("per_irq_cleared", 32'(irq), 0);
    tick(3);
    chk("per_irq_reset", 32'(irq), 1);
    wait_ns(60, "sim_reach60");
    wr(3'd3, 1, 1'b1, "sim_w1c_match_clr");
    chk("sim_irq1", 32'(irq), 1);
    tick(1);
    chk("sim_irq2", 32'(irq), 1);
    rd(3'd3, d);
    chk("sim_status", d, 1);
    wr(3'd0, 0, 1'b0, "z_stop");
    wr(3'd3, 1, 1'b0, "z_w1c");
    wr(3'd1, 0, 1'b0, "z_cmp0");
    ovf = 1'b1;
    wr(3'd0, 5, 1'b1, "z_arm_clr");
    base = clr_cnt;
    tick(8);
    chk("z_no_clr", 32'(clr_cnt - base), 0);
    chk("z_irq", 32'(irq), 0);
    rd(3'd3, d);
    chk("z_status_ovf", d, 2);
    e = 32'(ns);
    rd(3'd2, d);
    chk("count_rd", d, e);
    wr(3'd2, 0, 1'b1, "count_wr_clr");
    e = 32'(ns);
    rd(3'd2, d);
    chk("count_rd_after_clr", d, e);
    chk("count_cleared", e, 0);
    rd(3'd0, d);
    chk("ctrl_rd", d, 5);
    wr(3'd1, 32'hFFFF_FFFF, 1'b0, "cmp_wide_wr");
    rd(3'd1, d);
    chk("cmp_trunc_rd", d, 32'h3FFF_FFFF);
    wr(3'd5, 32'hFFFF_FFFF, 1'b0, "idx5_wr");
    rd(3'd5, d);
    chk("idx5_rd", d, 0);
    rd(3'd7, d);
    chk("idx7_rd", d, 0);
    ovf = 1'b0;
    rd(3'd3, d);
    chk("status_ovf_clear", d, 0);
    wr(3'd0, 0, 1'b0, "mc_stop0");
`ifdef TIMER_CTRL_MATCH_CNT_EN
    wr(3'd4, 0, 1'b0, "mc_clr0");
    wr(3'd3, 1, 1'b0, "mc_w1c");
    wr(3'd1, 20, 1'b0, "mc_cmp");
    wr(3'd0, 3, 1'b1, "mc_arm_clr");
    tick(10);
    wr(3'd0, 0, 1'b0, "mc_stop");
    rd(3'd4, d);
    chk("mcnt_5", d, 5);
    chk("mcnt_sat", rdata2, 3);
    wr(3'd4, 0, 1'b0, "mc_clr");
    rd(3'd4, d);
    chk("mcnt_cleared", d, 0);
`else
    wr(3'd4, 32'hFFFF_FFFF, 1'b0, "mc_wr_ignored");
    rd(3'd4, d);
    chk("mcnt_absent", d, 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/timer_ctrl.md
Name: timer_ctrl

Overview:
- Bus-mapped control and compare stage that sits directly downstream of the ns hardware timer.
- Consumes the timer's ns count and sticky overflow flag, and drives the timer's synchronous clear input.
- Compares the count against a software compare value and raises a level interrupt to the core.
- Provides one-shot and periodic (auto-clear) modes through a small word-addressed register file.

Parameters:
- NS_CNT_WIDTH, 30, width of the ns count input and of the CMP register; 1..32.
- CNT_W, 16, width of the match counter; used only with the optional feature.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, asynchronous active-low reset.
- sel_i, input, 1, bus access valid this cycle.
- we_i, input, 1, 1 = write, 0 = read; qualified by sel_i.
- addr_i, input, 3, word index of the register.
- wdata_i, input, 32, write data.
- rdata_o, output, 32, read data, registered.
- ns_cnt_i, input, NS_CNT_WIDTH, timer count.
- overflow_was_i, input, 1, timer sticky overflow flag.
- to_clear_timer_o, output, 1, one-cycle synchronous clear request to the timer.
- irq_o, output, 1, level interrupt.

Behaviour:
- Reset values: all outputs 0. CTRL=0, CMP=0, STATUS=0, match counter=0. State=IDLE.
- Register map (word index):
  - 0 CTRL (rw): bit0 EN, bit1 PERIODIC, bit2 IRQ_EN.
  - 1 CMP (rw): low NS_CNT_WIDTH bits.
  - 2 COUNT: reads zero-extended ns_cnt_i. Any write pulses to_clear_timer_o.
  - 3 STATUS: bit0 PEND (write 1 clears), bit1 OVF (read-only mirror of overflow_was_i).
  - 4 MCNT: see Optional Feature.
  - Other indices: read 0, writes ignored.
- Reads: rdata_o updates on the cycle after sel_i & ~we_i. Otherwise rdata_o holds its value.
- Writes: take effect on the clock edge where sel_i & we_i is sampled.
- Match condition: EN & (CMP != 0) & (ns_cnt_i >= CMP), unsigned compare. ">=" is required because the timer advances by more than 1 per cycle. CMP=0 never matches.
- FSM:
  - IDLE: EN=0. When CTRL is written with EN=1, pulse to_clear_timer_o for one cycle and go to ARMED.
  - ARMED: on match, set PEND.
    - If PERIODIC: pulse to_clear_timer_o and go to RELOAD.
    - Else: go to DONE.
  - RELOAD: one cycle, comparison masked because the count is still stale. Then return to ARMED.
  - DONE: no further matches. Re-arm only by writing CTRL with EN=1 (clear pulse, then ARMED).
  - Any state: a CTRL write with EN=0 goes to IDLE. No clear pulse, PEND unchanged.
- irq_o = PEND & IRQ_EN, registered (1 cycle after PEND sets).
- Simultaneous events:
  - PEND set by a match and a W1C write in the same cycle: the set wins.
  - CTRL EN=1 write during ARMED: restarts, with a clear pulse.
  - A COUNT write and a periodic reload in the same cycle produce a single clear pulse.
- CMP write while ARMED: the new value is compared from the next cycle.
- Reset mid-operation: everything returns to reset values immediately (asynchronous). to_clear_timer_o deasserts immediately.

Optional Feature:
- Macro: TIMER_CTRL_MATCH_CNT_EN.
- Defined:
  - A CNT_W-bit counter increments on every match.
  - It saturates at all-ones; there is no wrap.
  - It is readable at index 4, zero-extended.
  - Any write to index 4 clears it. If that write coincides with a match, the counter ends at 1.
- Not defined: index 4 reads 0, writes are ignored, and no counter flops exist.

Test Plan:
- Reset, then read indices 0–4 -> all read 0; irq_o=0; to_clear_timer_o=0.
- CMP=100, CTRL=0b101 (one-shot, IRQ_EN), count stepping by 20 -> exactly one clear pulse at arm. PEND sets when count reaches 100. irq_o=1 one cycle later. Count continues past 200 with no further clear.
- CMP=60, CTRL=0b111 (periodic), count stepping by 20 -> clear pulse every 4 cycles (arm, 20, 40, 60 → clear). Count never exceeds 60. PEND stays 1 until a W1C to STATUS, after which it re-sets on the next match.
- W1C to STATUS in the same cycle as a match -> PEND remains 1 and irq_o remains 1.
- CMP=0, EN=1, overflow_was_i=1 -> no match, irq_o=0. STATUS reads 0x2.
- With TIMER_CTRL_MATCH_CNT_EN and periodic CMP=20 -> after 5 matches MCNT=5. Write to index 4 -> MCNT=0. With CNT_W=2, after 5 matches MCNT=3 (saturated).
